mem_xform_engine: RTL

//   Parametrised memory transform engine: on i_start, reads i_len consecutive words from i_src_addr,

---
 rtl/mem_xform_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_xform_engine.sv
// Memory transform engine: reads i_len words, applies a mode-selected op, writes them back out.
// Optional checksum output o_csum enabled with `define MEM_XFORM_CSUM_EN.
module mem_xform_engine #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_operand,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_read_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [DATA_W-1:0] o_data
`ifdef MEM_XFORM_CSUM_EN
   ,output logic [DATA_W-1:0] o_csum
`endif
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // state   | meaning
    // S_IDLE  | waiting for i_start
    // S_READ  | read strobe out for current word
    // S_WAIT  | counting down read latency, capture i_data at terminal count
    // S_WRITE | write strobe out; pick next word or finish
    // S_DONE  | o_done pulse, start ignored
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        mode;
    logic [DATA_W-1:0] operand;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] csum;

    always_comb begin
        result = i_data;
        case (mode)
            2'b00:   result = i_data << operand[SH_W-1:0];
            2'b01:   result = i_data + operand;
            2'b10:   result = i_data ^ operand;
            default: result = i_data;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            dst          <= '0;
            remaining    <= '0;
            mode         <= '0;
            operand      <= '0;
            wait_cnt     <= '0;
            csum         <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_read_en    <= 1'b0;
            o_read_addr  <= '0;
            o_write_en   <= 1'b0;
            o_write_addr <= '0;
            o_data       <= '0;
        end else begin
            o_read_en  <= 1'b0;
            o_write_en <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        dst       <= i_dst_addr;
                        remaining <= i_len;
                        mode      <= i_mode;
                        operand   <= i_operand;
                        csum      <= '0;
                        if (i_len == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= S_READ;
                            o_read_en   <= 1'b1;
                            o_read_addr <= i_src_addr;
                            o_busy      <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state    <= S_WAIT;
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                end
                S_WAIT: begin
                    // terminal count lands on the cycle i_data is valid
                    if (wait_cnt == '0) begin
                        state        <= S_WRITE;
                        o_write_en   <= 1'b1;
                        o_write_addr <= dst;
                        o_data       <= result;
                        csum         <= csum ^ result;
                        dst          <= dst + 1'b1;
                        remaining    <= remaining - 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (remaining == '0) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        state       <= S_READ;
                        o_read_en   <= 1'b1;
                        o_read_addr <= o_read_addr + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_XFORM_CSUM_EN
    assign o_csum = csum;
`else
    logic unused_csum;
    assign unused_csum = ^csum;
`endif

endmodule
